// File: rtl/cache_2way_wb.sv
// rtl/cache_2way_wb.sv - 2-way set-associative write-back write-allocate data cache
//
// Purpose: data cache between a word-addressed 32-bit processor port and a
// block-wide memory port. True LRU per set (one bit naming the next victim).
//
// Ports:
//   clk, proc_reset        clock, synchronous active-high reset
//   proc_read/proc_write   request strobes (write wins), held while proc_stall=1
//   proc_addr, proc_wdata  word address, write data
//   proc_stall, proc_rdata request not complete / read data on a read hit
//   mem_read, mem_write    block fill / block write-back request
//   mem_addr, mem_wdata    block address, write-back block
//   mem_rdata, mem_ready   fill block, one-cycle completion pulse
//   hit_cnt, miss_cnt      saturating counters, only with CACHE_PERF_CNT_EN
//
// Optional feature macro: CACHE_PERF_CNT_EN
module cache_2way_wb #(
    parameter int ADDR_W = 30,
    parameter int WORDS  = 4,
    parameter int SETS   = 4,
    localparam int OFF_W = $clog2(WORDS),
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W,
    localparam int BLK_W = 32 * WORDS
) (
    input  logic                    clk,
    input  logic                    proc_reset,
    input  logic                    proc_read,
    input  logic                    proc_write,
    input  logic [ADDR_W-1:0]       proc_addr,
    input  logic [31:0]             proc_wdata,
    output logic                    proc_stall,
    output logic [31:0]             proc_rdata,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_W-OFF_W-1:0] mem_addr,
    output logic [BLK_W-1:0]        mem_wdata,
    input  logic [BLK_W-1:0]        mem_rdata,
    input  logic                    mem_ready
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Per-set storage; bit/entry [w] belongs to way w.
    logic [1:0]       valid_q [SETS];
    logic [1:0]       valid_d [SETS];
    logic [1:0]       dirty_q [SETS];
    logic [1:0]       dirty_d [SETS];
    logic [TAG_W-1:0] tag_q   [2][SETS];
    logic [TAG_W-1:0] tag_d   [2][SETS];
    logic [BLK_W-1:0] data_q  [2][SETS];
    logic [BLK_W-1:0] data_d  [2][SETS];
    logic [SETS-1:0]  lru_q, lru_d;
    logic             victim_q, victim_d;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_off;
    logic             req;
    logic             hit0, hit1, hit, hit_way;
    logic [BLK_W-1:0] hit_blk, wr_blk;
    logic [31:0]      hit_word;
    logic             vsel;

    assign req_tag = proc_addr[ADDR_W-1:IDX_W+OFF_W];
    assign req_idx = proc_addr[IDX_W+OFF_W-1:OFF_W];
    assign req_off = proc_addr[OFF_W-1:0];
    assign req     = proc_read | proc_write;

    assign hit0    = valid_q[req_idx][0] && (tag_q[0][req_idx] == req_tag);
    assign hit1    = valid_q[req_idx][1] && (tag_q[1][req_idx] == req_tag);
    assign hit     = hit0 | hit1;
    assign hit_way = hit1;
    assign hit_blk = hit1 ? data_q[1][req_idx] : data_q[0][req_idx];

    // Prefer an empty way (way 0 first) before evicting the LRU way.
    assign vsel = !valid_q[req_idx][0] ? 1'b0 :
                  !valid_q[req_idx][1] ? 1'b1 : lru_q[req_idx];

    always_comb begin
        hit_word = '0;
        wr_blk   = hit_blk;
        for (int k = 0; k < WORDS; k++) begin
            if (req_off == k[OFF_W-1:0]) begin
                hit_word            = hit_blk[32*k +: 32];
                wr_blk[32*k +: 32]  = proc_wdata;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        tag_d      = tag_q;
        data_d     = data_q;
        lru_d      = lru_q;
        victim_d   = victim_q;
        proc_stall = 1'b0;
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (proc_write) begin
                            data_d[hit_way][req_idx]  = wr_blk;
                            dirty_d[req_idx][hit_way] = 1'b1;
                        end else begin
                            proc_rdata = hit_word;
                        end
                        lru_d[req_idx] = ~hit_way;
                    end else begin
                        proc_stall = 1'b1;
                        victim_d   = vsel;
                        if (valid_q[req_idx][vsel] && dirty_q[req_idx][vsel])
                            state_d = S_WRITEBACK;
                        else
                            state_d = S_ALLOCATE;
                    end
                end
            end

            S_WRITEBACK: begin
                // Victim storage is untouched here, so these stay constant.
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {tag_q[victim_q][req_idx], req_idx};
                mem_wdata  = data_q[victim_q][req_idx];
                if (mem_ready)
                    state_d = S_ALLOCATE;
            end

            S_ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = proc_addr[ADDR_W-1:OFF_W];
                if (mem_ready) begin
                    data_d[victim_q][req_idx]  = mem_rdata;
                    tag_d[victim_q][req_idx]   = req_tag;
                    valid_d[req_idx][victim_q] = 1'b1;
                    dirty_d[req_idx][victim_q] = 1'b0;
                    state_d                    = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q  <= S_IDLE;
            lru_q    <= '0;
            victim_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            state_q  <= state_d;
            lru_q    <= lru_d;
            victim_q <= victim_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
        end
    end

    // Tags and data are meaningless while invalid, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

`ifdef CACHE_PERF_CNT_EN
    logic        retry_q, retry_d;
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        // The first IDLE cycle after a fill is the retry of the counted miss.
        retry_d    = (state_q == S_ALLOCATE) && mem_ready;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == S_IDLE && req) begin
            if (hit && !retry_q && hit_cnt_q != 32'hFFFF_FFFF)
                hit_cnt_d = hit_cnt_q + 32'd1;
            if (!hit && miss_cnt_q != 32'hFFFF_FFFF)
                miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            retry_q    <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            retry_q    <= retry_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_2way_wb.sv
// tb/tb_cache_2way_wb.sv - self-checking bench for cache_2way_wb against a recency-list cache model
module tb_cache_2way_wb;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    cache_2way_wb dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: per set, resident lines ordered most-recent first; backing memory by block address.
    int           cnt     [4];
    logic [25:0]  m_tag   [4][2];
    logic [127:0] m_data  [4][2];
    bit           m_dirty [4][2];
    logic [127:0] mem [logic [27:0]];
    int           exp_hit;
    int           exp_miss;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mem_get(input logic [27:0] a);
        logic [127:0] b;
        logic [1:0]   kk;
        if (mem.exists(a)) return mem[a];
        for (int k = 0; k < 4; k++) begin
            kk = k[1:0];
            b[32*k +: 32] = {a, kk, 2'b01};
        end
        return b;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 4; s++) cnt[s] = 0;
        exp_hit  = 0;
        exp_miss = 0;
    endtask

    task automatic do_reset();
        proc_reset = 1'b1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        mem_ready  = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_stall", proc_stall, 0);
        chk("rst_rdata", proc_rdata, 0);
        chk("rst_mem_rw", {mem_read, mem_write}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(posedge clk); #1;
        proc_reset = 1'b0;
        model_clear();
    endtask

    // One complete processor access; lat<0 picks a random memory wait (0..3 cycles).
    task automatic access(input bit wr, input logic [29:0] a, input logic [31:0] wd, input int lat);
        logic [1:0]   s;
        logic [25:0]  t;
        int           oi;
        logic [27:0]  b;
        int           hw;
        int           l;
        logic [127:0] blk;
        logic [25:0]  tt;
        logic [127:0] td;
        bit           tdi;
        s  = a[3:2];
        t  = a[29:4];
        oi = int'(a[1:0]);
        b  = a[29:2];
        hw = -1;
        for (int i = 0; i < cnt[s]; i++) if (m_tag[s][i] == t) hw = i;
        proc_read  = !wr;
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = wd;
        if (hw < 0) begin
            exp_miss++;
            @(negedge clk);
            chk("miss_stall", proc_stall, 1);
            chk("miss_idle_mem_rw", {mem_read, mem_write}, 0);
            @(posedge clk); #1;
            if (cnt[s] == 2 && m_dirty[s][1]) begin
                l = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
                for (int i = 0; i <= l; i++) begin
                    mem_ready = (i == l);
                    @(negedge clk);
                    chk("wb_stall", proc_stall, 1);
                    chk("wb_mem_rw", {mem_read, mem_write}, 2'b01);
                    chk("wb_addr", mem_addr, {m_tag[s][1], s});
                    chk("wb_data", mem_wdata, m_data[s][1]);
                    @(posedge clk); #1;
                    mem_ready = 1'b0;
                end
                mem[{m_tag[s][1], s}] = m_data[s][1];
            end
            l   = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
            blk = mem_get(b);
            for (int i = 0; i <= l; i++) begin
                mem_ready = (i == l);
                mem_rdata = (i == l) ? blk : {$urandom, $urandom, $urandom, $urandom};
                @(negedge clk);
                chk("al_stall", proc_stall, 1);
                chk("al_mem_rw", {mem_read, mem_write}, 2'b10);
                chk("al_addr", mem_addr, b);
                @(posedge clk); #1;
                mem_ready = 1'b0;
            end
            m_tag[s][1]   = m_tag[s][0];
            m_data[s][1]  = m_data[s][0];
            m_dirty[s][1] = m_dirty[s][0];
            m_tag[s][0]   = t;
            m_data[s][0]  = blk;
            m_dirty[s][0] = 1'b0;
            if (cnt[s] < 2) cnt[s]++;
        end else begin
            exp_hit++;
            if (hw == 1) begin
                tt = m_tag[s][0];   td = m_data[s][0];   tdi = m_dirty[s][0];
                m_tag[s][0] = m_tag[s][1]; m_data[s][0] = m_data[s][1]; m_dirty[s][0] = m_dirty[s][1];
                m_tag[s][1] = tt;   m_data[s][1] = td;   m_dirty[s][1] = tdi;
            end
        end
        @(negedge clk);
        chk("hit_stall", proc_stall, 0);
        chk("hit_rdata", proc_rdata, wr ? 32'h0 : m_data[s][0][32*oi +: 32]);
        chk("hit_mem_rw", {mem_read, mem_write}, 0);
        if (wr) begin
            m_data[s][0][32*oi +: 32] = wd;
            m_dirty[s][0] = 1'b1;
        end
        @(posedge clk); #1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
    endtask

    task automatic chk_cnt(input string tag);
`ifdef CACHE_PERF_CNT_EN
        @(negedge clk);
        chk({tag, "_hit_cnt"}, hit_cnt, exp_hit);
        chk({tag, "_miss_cnt"}, miss_cnt, exp_miss);
`else
        chk({tag, "_idle_stall"}, proc_stall, 0);
`endif
    endtask

    initial begin
        proc_reset = 1'b1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        model_clear();

        // Cold read miss with a 3-cycle memory wait.
        do_reset();
        mem[28'h4] = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        access(0, 30'h11, 32'h0, 3);
        access(0, 30'h10, 32'h0, -1);
        access(0, 30'h13, 32'h0, -1);
        access(0, 30'h12, 32'h0, -1);
        chk_cnt("cold");

        // Dirty eviction of way 0 after way 1 is filled.
        do_reset();
        access(0, 30'h00, 32'h0, -1);
        access(1, 30'h01, 32'hDEAD_BEEF, -1);
        access(0, 30'h10, 32'h0, -1);
        access(0, 30'h20, 32'h0, -1);

        // LRU order: 0x10 line is replaced, 0x00 stays resident.
        do_reset();
        access(0, 30'h00, 32'h0, -1);
        access(0, 30'h10, 32'h0, -1);
        access(0, 30'h00, 32'h0, -1);
        access(0, 30'h20, 32'h0, -1);
        access(0, 30'h00, 32'h0, -1);

        // Slow memory: 10 wait cycles before the fill completes.
        access(0, 30'h35, 32'h0, 10);

        // Reset while a write-back is pending.
        do_reset();
        access(1, 30'h01, 32'h1234_5678, -1);
        access(0, 30'h11, 32'h0, -1);
        proc_read = 1'b1;
        proc_addr = 30'h21;
        @(negedge clk);
        chk("rwb_miss_stall", proc_stall, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rwb_in_wb", {mem_read, mem_write}, 2'b01);
        @(posedge clk); #1;
        proc_reset = 1'b1;
        proc_read  = 1'b0;
        @(posedge clk); #1;
        proc_reset = 1'b0;
        @(negedge clk);
        chk("rwb_after_mem_rw", {mem_read, mem_write}, 0);
        chk("rwb_after_stall", proc_stall, 0);
        model_clear();
        @(posedge clk); #1;
        access(0, 30'h01, 32'h0, -1);

        // Randomized traffic over a small address range to force conflicts.
        for (int n = 0; n < 300; n++)
            access(1'($urandom_range(0, 1)), 30'($urandom_range(0, 63)), $urandom, -1);
        chk_cnt("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_2way_wb.md
Name: cache_2way_wb

Overview:
- Parametrised 2-way set-associative, write-back, write-allocate data cache.
- Sits between the processor (word-addressed, 32-bit data) and the block-wide memory interface.
- Replaces the fixed 8-line direct-mapped cache. Sets and block size are parameters; replacement is true LRU per set.

Parameters:
- ADDR_W, 30: processor word-address width.
- WORDS, 4: 32-bit words per block; power of 2, ≥2.
- SETS, 4: number of sets; power of 2, ≥2.
- Derived: OFF_W=log2(WORDS), IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W, BLK_W=32*WORDS.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- proc_reset  in  1  synchronous, active-high reset.
- proc_read  in  1  read request.
- proc_write  in  1  write request; wins if both read and write are high.
- proc_addr  in  ADDR_W  word address: tag=[ADDR_W-1:IDX_W+OFF_W], index=[IDX_W+OFF_W-1:OFF_W], offset=[OFF_W-1:0].
- proc_wdata  in  32  write data.
- proc_stall  out  1  request not complete this cycle.
- proc_rdata  out  32  read data, valid when proc_read=1 and proc_stall=0.
- mem_read  out  1  block fill request.
- mem_write  out  1  block write-back request.
- mem_addr  out  ADDR_W-OFF_W  block address.
- mem_wdata  out  BLK_W  write-back block.
- mem_rdata  in  BLK_W  fill block; word k occupies bits [32k+31:32k].
- mem_ready  in  1  single-cycle completion pulse for the current mem request.

Behaviour:
- Storage per set per way: valid, dirty, tag, block. One LRU bit per set, naming the way to replace next.
- Reset: state=IDLE; all valid, dirty and LRU bits cleared. Tags and data are don't-care. mem_read=mem_write=0, mem_addr=0, mem_wdata=0, proc_rdata=0, proc_stall=0.
- Reset mid-transaction: the request is abandoned. mem_read/mem_write are low from the cycle after the reset edge. Cache contents are invalidated.
- Request handling: proc_* must be held stable while proc_stall=1. mem_ready is ignored in IDLE.
- IDLE state:
  - hit = valid & tag match in either way. Hit logic is combinational.
  - Read hit: proc_stall=0 and proc_rdata=word[offset] in the same cycle. Otherwise proc_rdata=0.
  - Write hit: proc_stall=0; the word is written on the edge; the line's dirty bit is set.
  - Any hit sets the set's LRU bit to the other way.
  - Miss (request present, no hit): proc_stall=1. Victim = first invalid way (way 0 preferred), else the LRU way. Victim is latched.
  - Next state: WRITEBACK if the victim is valid and dirty, else ALLOCATE.
  - No request: proc_stall=0; no state change.
- WRITEBACK state: proc_stall=1, mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim block. All held constant until mem_ready, then go to ALLOCATE.
- ALLOCATE state: proc_stall=1, mem_read=1, mem_addr=proc_addr[ADDR_W-1:OFF_W], held until mem_ready. On the mem_ready edge: victim block←mem_rdata, tag←request tag, valid=1, dirty=0. Then go to IDLE.
- Retry after fill: in IDLE the request now hits and completes in 1 cycle. Miss latency = 1 (detect) + write-back wait + fill wait + 1 (retry).
- mem_read and mem_write are never high simultaneously.

Optional Feature:
- Macro: CACHE_PERF_CNT_EN.
- Defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0], both cleared by reset and saturating at 0xFFFFFFFF.
  - miss_cnt +1 on each IDLE→WRITEBACK/ALLOCATE transition.
  - hit_cnt +1 on each IDLE cycle with a request and a hit, except the retry cycle that directly follows ALLOCATE.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Defaults used throughout: index=addr[3:2], offset=[1:0], mem_addr=addr[29:2].
- Cold read miss: reset, read 0x11 → stall=1, mem_read=1, mem_addr=0x4. mem_ready after 3 cycles with rdata={D,C,B,A} → ALLOCATE→IDLE, next cycle stall=0, rdata=B.
- Dirty eviction: fill 0x00; write 0xDEADBEEF to 0x01 (hit, stall=0); read 0x10 (fills way 1); read 0x20 → mem_write=1, mem_addr=0x0, mem_wdata[63:32]=0xDEADBEEF. After mem_ready → mem_read=1, mem_addr=0x8.
- LRU order: read 0x00, 0x10, 0x00, then 0x20 → no write-back; mem_read with mem_addr=0x8 replaces the 0x10 line. A following read of 0x00 hits with stall=0.
- Slow memory: hold mem_ready=0 for 10 cycles in ALLOCATE → mem_read=1, mem_addr and proc_stall=1 stable every cycle. mem_ready=1 on 11th → completes.
- Reset during WRITEBACK: assert proc_reset 1 cycle → next cycle mem_write=0, stall=0 with no request. A read of a previously cached address misses (mem_read=1).
- CACHE_PERF_CNT_EN: cold miss + 3 hits → miss_cnt=1, hit_cnt=3.
